// File: rtl/sram_arbiter.sv
// SRAM arbiter: one shared 16-bit async SRAM, camera write path and readout requester.
// Writes are buffered in a 2-entry FIFO and take priority. A starvation counter forces a
// read grant after MAX_WAIT consecutive writes while a read is pending.
module sram_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              pclk,
  input  logic              rst,
  // write path
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              wr_lane,
  output logic              wr_ack,
  output logic              wr_overflow,
  // read path
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [15:0]       rd_data,
  // SRAM pins
  output logic [ADDR_W-1:0] Address,
  output logic [15:0]       DataOut,
  output logic              Data_oe,
  input  logic [15:0]       DataIn,
  output logic              CEb,
  output logic              OEb,
  output logic              WEb,
  output logic              BLEb,
  output logic              BHEb
);

  typedef enum logic [2:0] {StIdle, StWSetup, StWPulse, StRSetup, StRSample} state_e;

  localparam logic [2:0] MaxWait = 3'(MAX_WAIT);

  state_e state_q;

  // write FIFO storage
  logic [ADDR_W-1:0] fifo_addr_q [2];
  logic [7:0]        fifo_data_q [2];
  logic              fifo_lane_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  logic [2:0]        starve_q;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic grant_pt;
  logic starve_ok;
  logic grant_wr;
  logic grant_rd;

  logic [ADDR_W-1:0] head_addr;
  logic [7:0]        head_data;
  logic              head_lane;

  // FIFO status, grant decision and head-of-queue selection
  always_comb begin
    fifo_full  = (count_q == 2'd2);
    fifo_empty = (count_q == 2'd0);
    wr_ack     = ~fifo_full;
    push       = wr_req & ~fifo_full;
    grant_pt   = (state_q == StIdle) || (state_q == StWPulse) || (state_q == StRSample);
    starve_ok  = (starve_q < MaxWait);
    // Write wins unless the starvation limit is hit with a read waiting.
    grant_wr   = grant_pt & ~fifo_empty & (starve_ok | ~rd_req);
    grant_rd   = grant_pt & rd_req & ~(~fifo_empty & starve_ok);
    pop        = grant_wr;
    head_addr  = fifo_addr_q[rd_ptr_q];
    head_data  = fifo_data_q[rd_ptr_q];
    head_lane  = fifo_lane_q[rd_ptr_q];
  end

  // Write FIFO: push from the camera side, pop on a write grant
  always_ff @(posedge pclk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= wr_addr;
        fifo_data_q[wr_ptr_q] <= wr_data;
        fifo_lane_q[wr_ptr_q] <= wr_lane;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow: a request arrived while the FIFO was full
  always_ff @(posedge pclk) begin
    if (rst) begin
      wr_overflow <= 1'b0;
    end else if (wr_req && fifo_full) begin
      wr_overflow <= 1'b1;
    end
  end

  // Starvation counter: consecutive write grants while a read is waiting
  always_ff @(posedge pclk) begin
    if (rst) begin
      starve_q <= 3'd0;
    end else if (grant_rd || !rd_req) begin
      starve_q <= 3'd0;
    end else if (grant_wr && (starve_q != 3'd7)) begin
      starve_q <= starve_q + 3'd1;
    end
  end

  // Access sequencer with registered SRAM pins and read handshake
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= StIdle;
      Address  <= '0;
      DataOut  <= '0;
      Data_oe  <= 1'b0;
      CEb      <= 1'b1;
      OEb      <= 1'b1;
      WEb      <= 1'b1;
      BLEb     <= 1'b1;
      BHEb     <= 1'b1;
      rd_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_ack   <= 1'b0;
      rd_valid <= 1'b0;
      if (state_q == StRSample) begin
        rd_data  <= DataIn;
        rd_valid <= 1'b1;
      end
      case (state_q)
        StWSetup: begin
          // address, data and lanes stay put across the strobe
          state_q <= StWPulse;
          WEb     <= 1'b0;
        end
        StRSetup: begin
          state_q <= StRSample;
        end
        default: begin
          if (grant_wr) begin
            state_q <= StWSetup;
            Address <= head_addr;
            DataOut <= {head_data, head_data};
            Data_oe <= 1'b1;
            CEb     <= 1'b0;
            OEb     <= 1'b1;
            WEb     <= 1'b1;
            BLEb    <= head_lane;
            BHEb    <= ~head_lane;
          end else if (grant_rd) begin
            state_q <= StRSetup;
            Address <= rd_addr;
            Data_oe <= 1'b0;
            CEb     <= 1'b0;
            OEb     <= 1'b0;
            WEb     <= 1'b1;
            BLEb    <= 1'b0;
            BHEb    <= 1'b0;
            rd_ack  <= 1'b1;
          end else begin
            // idle: release the bus, keep Address/DataOut
            state_q <= StIdle;
            Data_oe <= 1'b0;
            CEb     <= 1'b1;
            OEb     <= 1'b1;
            WEb     <= 1'b1;
            BLEb    <= 1'b1;
            BHEb    <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
